// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default rates and the
// oversample divisor helper used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int CLK_FREQ_DEFAULT = 100_000_000;
  localparam int BAUD_DEFAULT     = 9600;

  // Integer-floor clocks per oversample tick.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks; the
// synchronous clear restarts the period so sampling can align to an edge.
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  // DIV = 1 would give a zero-width counter; keep one bit that stays at 0.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q == TOP) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = !clr_i && (cnt_q == TOP);

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 receiver with a valid/ready output register.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
//
//   state    | meaning
//   IDLE     | line idle, waiting for a synced low
//   START    | confirming the start bit at mid-bit
//   DATA     | sampling payload bits, LSB first
//   PARITY   | sampling the parity bit (UART_RX_PARITY_EN only)
//   STOP     | sampling the stop bit, commit or flag framing error
//   BREAK    | line held low after a bad stop, wait for high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD       = BAUD_DEFAULT,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s1_q, rx_s2_q;
  rx_state_t            state_q;
  logic [SW-1:0]        samp_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 tick;
  logic                 tick_clr;
  logic                 bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Restart bit timing on the falling edge that leaves IDLE.
  assign tick_clr = (state_q == ST_IDLE) && !rx_s2_q;
  assign bit_end  = tick && (samp_q == S_END);

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (tick) samp_q <= (samp_q == S_END) ? '0 : samp_q + SW'(1);

      case (state_q)
        ST_IDLE: begin
          samp_q <= '0;
          if (!rx_s2_q) state_q <= ST_START;
        end
        ST_START: begin
          if (tick && samp_q == S_MID) begin
            samp_q <= '0;
            idx_q  <= '0;
            state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_q[idx_q] <= rx_s2_q;
            idx_q          <= idx_q + IW'(1);
            if (idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            par_q   <= rx_s2_q;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (rx_s2_q) begin
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              par_err_q <= ^{shift_q, par_q};
`endif
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s2_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at one tick per clock (16 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;

  int checks = 0;
  int errors = 0;

`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_vhi = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int         t_valid = 0;
  logic [7:0] last_data = 8'h00;
  logic       v_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_vhi     <= n_vhi + 1;
      last_data <= rx_data;
    end
    if (rx_valid && !v_prev) t_valid <= cyc;
    v_prev <= rx_valid;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (overrun)    n_ovr  <= n_ovr + 1;
    if (parity_err) n_perr <= n_perr + 1;
  end

  int b_vhi, b_ferr, b_ovr, b_perr, t_start;

  task automatic snap();
    b_vhi = n_vhi; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int stop_len, input int rst_bit, input logic par_flip);
    @(negedge clk);
    t_start = cyc;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == rst_bit) begin
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (16) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++;
    if ({rx_valid, frame_err, overrun, parity_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {rx_valid, frame_err, overrun, parity_err});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 16, -1, 1'b0);
    checks++;
    if (n_vhi - b_vhi !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", n_vhi - b_vhi); end
    checks++;
    if (last_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", last_data); end
    checks++;
    if (t_valid - t_start !== LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", t_valid - t_start, LAT); end
    checks++;
    if ((n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr) !== 0) begin
      errors++; $display("FAIL basic_errors: got %0d pulses want 0", (n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr));
    end
  endtask

  task automatic test_glitch();
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (n_vhi - b_vhi !== 0 || n_ferr - b_ferr !== 0) begin
      errors++; $display("FAIL glitch_quiet: got valid %0d ferr %0d want 0 0", n_vhi - b_vhi, n_ferr - b_ferr);
    end
    send_frame(8'h3C, 1'b1, 16, -1, 1'b0);
    checks++;
    if (n_vhi - b_vhi !== 1 || last_data !== 8'h3C) begin
      errors++; $display("FAIL glitch_next: got %0d/%h want 1/3c", n_vhi - b_vhi, last_data);
    end
  endtask

  task automatic test_break();
    snap();
    send_frame(8'h55, 1'b0, 56, -1, 1'b0);
    checks++;
    if (n_ferr - b_ferr !== 1) begin errors++; $display("FAIL break_ferr: got %0d want 1", n_ferr - b_ferr); end
    checks++;
    if (n_vhi - b_vhi !== 0) begin errors++; $display("FAIL break_valid: got %0d want 0", n_vhi - b_vhi); end
    send_frame(8'h0F, 1'b1, 16, -1, 1'b0);
    checks++;
    if (n_vhi - b_vhi !== 1 || last_data !== 8'h0F || n_ferr - b_ferr !== 1) begin
      errors++; $display("FAIL break_next: got %0d/%h ferr %0d want 1/0f 1", n_vhi - b_vhi, last_data, n_ferr - b_ferr);
    end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 16, -1, 1'b0);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL ovr_first: got %b/%h want 1/11", rx_valid, rx_data);
    end
    send_frame(8'h22, 1'b1, 16, -1, 1'b0);
    checks++;
    if (n_ovr - b_ovr !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", n_ovr - b_ovr); end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      errors++; $display("FAIL ovr_hold: got %b/%h want 1/11", rx_valid, rx_data);
    end
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_handshake: got valid %b want 0", rx_valid); end
    rx_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    snap();
    send_frame(8'hFF, 1'b1, 16, 3, 1'b0);
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %h/%b want 00/0", rx_data, rx_valid);
    end
    checks++;
    if (n_vhi - b_vhi + n_ferr - b_ferr + n_ovr - b_ovr + n_perr - b_perr !== 0) begin
      errors++; $display("FAIL rstmid_quiet: got %0d events want 0", n_vhi - b_vhi + n_ferr - b_ferr + n_ovr - b_ovr + n_perr - b_perr);
    end
    send_frame(8'h81, 1'b1, 16, -1, 1'b0);
    checks++;
    if (n_vhi - b_vhi !== 1 || last_data !== 8'h81) begin
      errors++; $display("FAIL rstmid_next: got %0d/%h want 1/81", n_vhi - b_vhi, last_data);
    end
  endtask

  task automatic test_parity();
    snap();
`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 16, -1, 1'b1);
    checks++;
    if (n_perr - b_perr !== 1) begin errors++; $display("FAIL parity_pulse: got %0d want 1", n_perr - b_perr); end
    checks++;
    if (n_vhi - b_vhi !== 1 || last_data !== 8'h03) begin
      errors++; $display("FAIL parity_commit: got %0d/%h want 1/03", n_vhi - b_vhi, last_data);
    end
`else
    send_frame(8'h03, 1'b1, 16, -1, 1'b0);
    checks++;
    if (n_perr - b_perr !== 0) begin errors++; $display("FAIL parity_tied: got %0d want 0", n_perr - b_perr); end
    checks++;
    if (n_vhi - b_vhi !== 1 || last_data !== 8'h03) begin
      errors++; $display("FAIL parity_data: got %0d/%h want 1/03", n_vhi - b_vhi, last_data);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
